// File: rtl/day5_pkg.sv
// day5_pkg: shared ASCII codes and parser state encoding for the day-5 front end
package day5_pkg;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;

    typedef enum logic [2:0] {
        S_RANGE_LO,
        S_RANGE_HI,
        S_ID,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/day5_dec_accum.sv
// day5_dec_accum: decimal accumulator step acc*10+digit with overflow detect
module day5_dec_accum #(
    parameter int WIDTH = 64
) (
    input  logic             clear,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] acc_next,
    output logic             overflow
);

    logic [WIDTH+3:0] wide;

    // x*10 = x*8 + x*2; four guard bits hold any carry out of WIDTH
    assign wide     = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{WIDTH{1'b0}}, digit};
    assign overflow = |wide[WIDTH+3:WIDTH];
    assign acc_next = clear ? '0 : digit_en ? wide[WIDTH-1:0] : acc;

endmodule

// File: rtl/day5_input_parser.sv
// day5_input_parser: byte-stream parser turning "a-b" range lines and "n" id lines into pulses
module day5_input_parser
    import day5_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             load_ranges,
    output logic [WIDTH-1:0] start_range,
    output logic [WIDTH-1:0] end_range,
    output logic [WIDTH-1:0] id,
    output logic             id_valid,
    output logic             ranges_loaded,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] range_count,
    output logic [CNT_W-1:0] id_count
);

    state_t state_q, state_d, st_after;
    logic [WIDTH-1:0] acc_q, acc_d, hold_q, hold_d;
    logic [WIDTH-1:0] start_q, start_d, end_q, end_d, id_q, id_d;
    logic [CNT_W-1:0] rc_q, rc_d, ic_q, ic_d;
    logic seen_q, seen_d, load_q, load_d, idv_q, idv_d, rl_q, rl_d;
    logic accept, is_digit, is_dash, is_lf, is_cr, den, clr, ovf;
    logic emit_r, emit_i, last_pending, id_pulse;

    assign in_ready = reset_n && (state_q inside {S_RANGE_LO, S_RANGE_HI, S_ID});
    assign accept   = in_valid && in_ready;
    assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    assign is_dash  = in_data == CH_DASH;
    assign is_lf    = in_data == CH_LF;
    assign is_cr    = in_data == CH_CR;
    assign den      = accept && is_digit;

    day5_dec_accum #(.WIDTH(WIDTH)) u_accum (
        .clear    (clr),
        .digit_en (den),
        .digit    (in_data[3:0]),
        .acc      (acc_q),
        .acc_next (acc_d),
        .overflow (ovf)
    );

    // state register; reset lands on the range-low field of an empty file
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_RANGE_LO;
        else          state_q <= state_d;
    end

    // effect of the accepted byte alone, before any end-of-file handling
    always_comb begin
        st_after = state_q;
        seen_d   = seen_q;
        clr      = 1'b0;
        emit_r   = 1'b0;
        emit_i   = 1'b0;
        if (accept && !is_cr) begin
            if (is_digit) begin
                seen_d = 1'b1;
                if (ovf) st_after = S_ERR;
            end else if (state_q == S_RANGE_LO) begin
                if (is_dash && seen_q) begin
                    st_after = S_RANGE_HI;
                    clr      = 1'b1;
                    seen_d   = 1'b0;
                end else if (is_lf && !seen_q) begin
                    st_after = S_ID;
                end else begin
                    st_after = S_ERR;
                end
            end else if (state_q == S_RANGE_HI) begin
                if (is_lf && seen_q && acc_q >= hold_q) begin
                    st_after = S_RANGE_LO;
                    emit_r   = 1'b1;
                    clr      = 1'b1;
                    seen_d   = 1'b0;
                end else begin
                    st_after = S_ERR;
                end
            end else if (is_lf) begin
                emit_i = seen_q;
                clr    = 1'b1;
                seen_d = 1'b0;
            end else begin
                st_after = S_ERR;
            end
        end
    end

    // end of file: only an id section or a clean range boundary may finish normally
    always_comb begin
        state_d = (accept && in_last && st_after != S_ERR)
                ? ((st_after == S_ID || (st_after == S_RANGE_LO && !seen_d)) ? S_DONE : S_ERR)
                : st_after;
    end

    // registered-output next values; an unterminated final id is flushed with the last byte
    always_comb begin
        last_pending = accept && in_last && st_after == S_ID && seen_d;
        id_pulse     = emit_i || last_pending;
        load_d       = emit_r;
        start_d      = emit_r ? hold_q : '0;
        end_d        = emit_r ? acc_q : '0;
        idv_d        = id_pulse;
        id_d         = id_pulse ? (is_digit ? acc_d : acc_q) : '0;
        rl_d         = rl_q || state_d == S_ID || state_d == S_DONE;
        hold_d       = (state_q == S_RANGE_LO && st_after == S_RANGE_HI) ? acc_q : hold_q;
        rc_d         = (emit_r && rc_q != '1) ? rc_q + CNT_W'(1) : rc_q;
        ic_d         = (id_pulse && ic_q != '1) ? ic_q + CNT_W'(1) : ic_q;
    end

    // datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            hold_q  <= '0;
            seen_q  <= 1'b0;
            load_q  <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
            idv_q   <= 1'b0;
            id_q    <= '0;
            rl_q    <= 1'b0;
            rc_q    <= '0;
            ic_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            seen_q  <= seen_d;
            load_q  <= load_d;
            start_q <= start_d;
            end_q   <= end_d;
            idv_q   <= idv_d;
            id_q    <= id_d;
            rl_q    <= rl_d;
            rc_q    <= rc_d;
            ic_q    <= ic_d;
        end
    end

    assign load_ranges   = load_q;
    assign start_range   = start_q;
    assign end_range     = end_q;
    assign id_valid      = idv_q;
    assign id            = id_q;
    assign ranges_loaded = rl_q;
    assign range_count   = rc_q;
    assign id_count      = ic_q;
    assign done          = state_q == S_DONE || state_q == S_ERR;
    assign error         = state_q == S_ERR;

endmodule

// File: tb/tb_day5_input_parser.sv
// tb_day5_input_parser: scoreboard bench with a line-level reference model of the puzzle file format
module tb_day5_input_parser;

    typedef logic [7:0] u8;
    typedef struct {
        bit          is_id;
        logic [63:0] a;
        logic [63:0] b;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready, load_ranges, id_valid, ranges_loaded, done, error;
    logic [63:0] start_range, end_range, id;
    logic [15:0] range_count, id_count;

    int  total = 0;
    int  bad = 0;
    u8   fq[$];
    ev_t exp_q[$];
    int  erc, eic;
    bit  erl, edone, eerr;
    ev_t e;

    day5_input_parser #(.WIDTH(64), .CNT_W(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .load_ranges   (load_ranges),
        .start_range   (start_range),
        .end_range     (end_range),
        .id            (id),
        .id_valid      (id_valid),
        .ranges_loaded (ranges_loaded),
        .done          (done),
        .error         (error),
        .range_count   (range_count),
        .id_count      (id_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // monitor: every pulse must match the next scoreboard entry; idle cycles carry zero fillers
    always @(negedge clock) begin
        if (reset_n) begin
            if (load_ranges || id_valid) begin
                chk("pulse_excl", {63'b0, load_ranges && id_valid}, 0);
                chk("pulse_expected", {63'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {63'b0, id_valid}, {63'b0, e.is_id});
                    if (e.is_id) chk("id_value", id, e.a);
                    else begin
                        chk("start_range", start_range, e.a);
                        chk("end_range", end_range, e.b);
                    end
                end
            end else begin
                chk("fillers", start_range | end_range | id, 0);
            end
        end
    end

    function automatic bit pnum(input u8 ln[$], input int s, input int en, output logic [63:0] v);
        logic [127:0] a = '0;
        v = '0;
        if (en <= s) return 0;
        for (int k = s; k < en; k++) begin
            if (ln[k] < 8'h30 || ln[k] > 8'h39) return 0;
            a = a * 10 + 128'(ln[k] - 8'h30);
            if (a > 128'hFFFF_FFFF_FFFF_FFFF) return 0;
        end
        v = a[63:0];
        return 1;
    endfunction

    // reference: split the file into lines (CR dropped), validate each line as a whole
    task automatic model();
        u8 ln[$];
        int i = 0;
        int ph = 0;
        int dp;
        bit term, ok1, ok2;
        logic [63:0] lo, hi, v;
        exp_q.delete();
        erc = 0; eic = 0; erl = 0; edone = 0; eerr = 0;
        forever begin
            ln.delete();
            term = 0;
            while (i < fq.size() && !term) begin
                if (fq[i] == 8'h0A) term = 1;
                else if (fq[i] != 8'h0D) ln.push_back(fq[i]);
                i++;
            end
            if (ph == 0) begin
                if (ln.size() == 0) begin
                    erl = 1;
                    ph = 1;
                    if (!term) begin edone = 1; break; end
                    continue;
                end
                if (!term) begin eerr = 1; break; end
                dp = -1;
                for (int k = 0; k < ln.size(); k++) if (dp < 0 && ln[k] == 8'h2D) dp = k;
                if (dp <= 0) begin eerr = 1; break; end
                ok1 = pnum(ln, 0, dp, lo);
                ok2 = pnum(ln, dp + 1, ln.size(), hi);
                if (!ok1 || !ok2 || lo > hi) begin eerr = 1; break; end
                exp_q.push_back('{0, lo, hi});
                erc++;
            end else begin
                if (ln.size() != 0) begin
                    if (!pnum(ln, 0, ln.size(), v)) begin eerr = 1; break; end
                    exp_q.push_back('{1, v, 64'd0});
                    eic++;
                end
                if (!term) begin edone = 1; break; end
            end
        end
        if (eerr) edone = 1;
    endtask

    task automatic add(input string s);
        for (int k = 0; k < s.len(); k++) fq.push_back(s[k]);
    endtask

    task automatic add_eol();
        if ($urandom_range(0, 3) == 0) fq.push_back(8'h0D);
        fq.push_back(8'h0A);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps; stops once the parser refuses bytes
    task automatic send(input int mode, input bit use_last);
        for (int i = 0; i < fq.size(); i++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            if (!in_ready) break;
            in_data  = fq[i];
            in_last  = use_last && (i == fq.size() - 1);
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_flags", {58'b0, load_ranges, id_valid, ranges_loaded, done, error, in_ready}, 0);
        chk("rst_values", start_range | end_range | id, 0);
        chk("rst_counts", {32'b0, range_count, id_count}, 0);
        @(negedge clock);
        exp_q.delete();
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic finish_file();
        repeat (3) @(negedge clock);
        chk("sb_empty", 64'(exp_q.size()), 0);
        chk("range_count", {48'b0, range_count}, 64'(erc));
        chk("id_count", {48'b0, id_count}, 64'(eic));
        chk("ranges_loaded", {63'b0, ranges_loaded}, {63'b0, erl});
        chk("done", {63'b0, done}, {63'b0, edone});
        chk("error", {63'b0, error}, {63'b0, eerr});
        chk("in_ready", {63'b0, in_ready}, {63'b0, !edone});
    endtask

    task automatic run_str(input string s, input int mode);
        do_reset();
        fq.delete();
        add(s);
        model();
        send(mode, 1);
    endtask

    task automatic gen_random();
        int nr, ni;
        logic [63:0] lo, hi, t;
        u8 corrupt_set[5];
        corrupt_set = '{8'h78, 8'h2D, 8'h0A, 8'h35, 8'h0D};
        nr = $urandom_range(0, 4);
        ni = $urandom_range(0, 4);
        fq.delete();
        for (int r = 0; r < nr; r++) begin
            lo = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 999));
            hi = lo + 64'($urandom_range(0, 300));
            if ($urandom_range(0, 9) == 0) begin t = lo; lo = hi; hi = t; end
            add($sformatf("%0d-%0d", lo, hi));
            add_eol();
        end
        if ($urandom_range(0, 9) != 0) add_eol();
        for (int k = 0; k < ni; k++) begin
            add($sformatf("%0d", 64'($urandom_range(0, 99999))));
            add_eol();
            if ($urandom_range(0, 5) == 0) add_eol();
        end
        if (fq.size() > 1 && fq[fq.size() - 1] == 8'h0A && $urandom_range(0, 2) == 0) void'(fq.pop_back());
        if (fq.size() > 0 && $urandom_range(0, 4) == 0) fq[$urandom_range(0, fq.size() - 1)] = corrupt_set[$urandom_range(0, 4)];
        if (fq.size() == 0) fq.push_back(8'h0A);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        run_str("3-5\n10-14\n\n1\n5\n", 0);
        chk("done_with_last_pulse", {62'b0, done, id_valid}, 3);
        finish_file();
        run_str("3-5\n10-14\n\n1\n5", 0);
        chk("done_same_edge", {62'b0, done, id_valid}, 3);
        finish_file();
        run_str("18446744073709551615-18446744073709551615\n\n", 2);
        finish_file();
        run_str("18446744073709551616-1\n", 0);
        finish_file();
        run_str("7-3\n", 0);
        finish_file();
        run_str("3-5\r\n\r\n9\r\n", 2);
        finish_file();
        run_str("12-20\n", 1);
        chk("latency_pulse", {63'b0, load_ranges}, 1);
        @(negedge clock);
        chk("latency_single", {63'b0, load_ranges}, 0);
        finish_file();
        do_reset();
        fq.delete();
        add("12");
        send(0, 0);
        run_str("4-6\n\n", 0);
        finish_file();
        for (int n = 0; n < 40; n++) begin
            do_reset();
            gen_random();
            model();
            send(2, 1);
            finish_file();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
